udp_tx: RTL

//  UDP transmit framer: sits between application TX stream and IPv4 TX payload input.

---
 rtl/udp_tx.sv | 128 ++++++++++++
 1 files changed

// File: rtl/udp_tx.sv
// UDP transmit framer: prepends an 8-byte UDP header to an application payload
// stream and forwards it to the IPv4 layer with ready/valid backpressure.
module udp_tx #(
  parameter int                 DATA_W   = 16,
  parameter int                 LEN_W    = 2,
  parameter int                 PORT_W   = 16,
  parameter logic [PORT_W-1:0]  SRC_PORT = 16'd18070,
  parameter logic [PORT_W-1:0]  DST_PORT = 16'd18070
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic              term_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [15:0]       udp_len_i,
  output logic              ready_o,
  input  logic              ready_i,
  output logic              valid_o,
  output logic              start_o,
  output logic              term_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              cancel_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    HEAD = 3'b010,
    DATA = 3'b100
  } state_t;

  state_t      state, state_n;
  logic [1:0]  hdr_cnt;
  logic [15:0] byte_cnt;
  logic [15:0] len_q;

  logic        start_req, start_ok, start_bad;
  logic        cancel_act, hdr_acc, data_acc;
  logic [16:0] byte_sum;
  logic [15:0] hdr_len;

  assign start_req  = valid_i & start_i;
  // 65527 is the largest payload whose UDP length (payload + 8) fits in 16 bits.
  assign start_bad  = start_req & ((udp_len_i == 16'd0) | (udp_len_i > 16'd65527));
  assign start_ok   = start_req & ~start_bad;
  assign cancel_act = cancel_i & (state != IDLE);
  assign hdr_acc    = (state == HEAD) & ready_i;
  assign data_acc   = (state == DATA) & valid_i & ready_i;
  assign byte_sum   = {1'b0, byte_cnt} + 17'(len_i);
  assign hdr_len    = len_q + 16'd8;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=) assignments.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_n and no latch is inferred.
    state_n = state;
    unique case (state)
      IDLE:    if (start_ok) state_n = HEAD;
      HEAD:    if (hdr_acc && hdr_cnt == 2'd3) state_n = DATA;
      DATA:    if (data_acc && term_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (cancel_act) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_cnt  <= 2'd0;
      byte_cnt <= 16'd0;
      len_q    <= 16'd0;
    end else begin
      if (state == IDLE && start_ok) len_q <= udp_len_i;

      if (cancel_act)   hdr_cnt <= 2'd0;
      else if (hdr_acc) hdr_cnt <= hdr_cnt + 2'd1;

      if (cancel_act)    byte_cnt <= 16'd0;
      else if (data_acc) byte_cnt <= term_i ? 16'd0 : byte_sum[15:0];
    end
  end

  always_comb begin
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    start_o  = 1'b0;
    term_o   = 1'b0;
    data_o   = '0;
    len_o    = '0;
    err_o    = 1'b0;
    cancel_o = cancel_act;
    unique case (state)
      IDLE: err_o = start_bad;
      HEAD: begin
        valid_o = 1'b1;
        len_o   = LEN_W'(2);
        start_o = (hdr_cnt == 2'd0);
        // Header fields go out big-endian: high byte is the first wire byte.
        unique case (hdr_cnt)
          2'd0:    data_o = {SRC_PORT[7:0], SRC_PORT[15:8]};
          2'd1:    data_o = {DST_PORT[7:0], DST_PORT[15:8]};
          2'd2:    data_o = {hdr_len[7:0], hdr_len[15:8]};
          default: data_o = 16'h0000;
        endcase
      end
      DATA: begin
        valid_o = valid_i;
        ready_o = ready_i;
        data_o  = data_i;
        len_o   = len_i;
        term_o  = valid_i & term_i;
        err_o   = data_acc & (term_i ? (byte_sum != {1'b0, len_q})
                                     : (byte_sum >= {1'b0, len_q}));
      end
      default: ;
    endcase
    if (cancel_act) err_o = 1'b0;
  end

endmodule
